scan_display_driver: RTL and testbench

Parametrised, self-timed multiplexing driver for an N-digit common-anode display. It generates its own scan timing from the system clock with a prescaler, and it keeps guard phases before and after each digit's on-window to suppress ghosting. Character and digit-enable data are double-buffered and committed only at frame boundaries, so the display never tears. It sits between the character-generation logic and the seven-segment decoder and anode pins.

---
 rtl/scan_display_driver_pkg.sv | 15 +
 rtl/scan_display_driver_timebase.sv | 74 +++++++
 rtl/scan_display_driver.sv | 140 ++++++++++++++
 tb/tb_scan_display_driver.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_display_driver_pkg.sv
// Shared defaults and width helper for the multiplexed display driver.
package scan_pkg;

    localparam int NUM_DIGITS_DEF  = 4;
    localparam int CHAR_W_DEF      = 4;
    localparam int TICK_DIV_DEF    = 16384;
    localparam int SLOT_PHASES_DEF = 4;
    localparam int ON_PHASE_DEF    = 2;

    // Index width for a counter over n values; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_display_driver_timebase.sv
// Prescaler, phase and digit counters; flags the tick that closes a frame.
module scan_timebase
    import scan_pkg::*;
#(
    parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
    parameter int TICK_DIV    = TICK_DIV_DEF,
    parameter int SLOT_PHASES = SLOT_PHASES_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    output logic                           tick,
    output logic [idx_w(SLOT_PHASES)-1:0] phase,
    output logic [idx_w(NUM_DIGITS)-1:0]  digit,
    output logic                           frame_end
);

    localparam int PS_W = idx_w(TICK_DIV);
    localparam int PH_W = idx_w(SLOT_PHASES);
    localparam int DG_W = idx_w(NUM_DIGITS);

    logic [PS_W-1:0] presc_q, presc_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [DG_W-1:0] digit_q, digit_d;
    logic            phase_last;
    logic            digit_last;

    assign phase_last = (phase_q == PH_W'(SLOT_PHASES - 1));
    assign digit_last = (digit_q == DG_W'(NUM_DIGITS - 1));
    assign tick       = enable && (presc_q == PS_W'(TICK_DIV - 1));
    assign frame_end  = tick && phase_last && digit_last;
    assign phase      = phase_q;
    assign digit      = digit_q;

    // Counter advance; a disabled timebase is held at zero.
    always_comb begin
        presc_d = presc_q;
        phase_d = phase_q;
        digit_d = digit_q;
        if (!enable) begin
            presc_d = '0;
            phase_d = '0;
            digit_d = '0;
        end else if (tick) begin
            presc_d = '0;
            if (phase_last) begin
                phase_d = '0;
                if (digit_last) begin
                    digit_d = '0;
                end else begin
                    digit_d = digit_q + DG_W'(1);
                end
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end else begin
            presc_d = presc_q + PS_W'(1);
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            phase_q <= '0;
            digit_q <= '0;
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/scan_display_driver.sv
// Multiplexing driver for a common-anode display: double-buffered character
// data committed at frame boundaries, guard-phased active-low anode drive.
module scan_display_driver
    import scan_pkg::*;
#(
    parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
    parameter int CHAR_W      = CHAR_W_DEF,
    parameter int TICK_DIV    = TICK_DIV_DEF,
    parameter int SLOT_PHASES = SLOT_PHASES_DEF,
    parameter int ON_PHASE    = ON_PHASE_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           load,
    input  logic [NUM_DIGITS*CHAR_W-1:0]   chars_in,
    input  logic [NUM_DIGITS-1:0]          digit_en_in,
    output logic [NUM_DIGITS-1:0]          an,
    output logic [CHAR_W-1:0]              char_out,
    output logic [idx_w(NUM_DIGITS)-1:0]   digit_idx,
    output logic                           pending,
    output logic                           frame_done
);

    localparam int PH_W = idx_w(SLOT_PHASES);
    localparam int DG_W = idx_w(NUM_DIGITS);
    localparam int CV_W = NUM_DIGITS * CHAR_W;

    if (NUM_DIGITS < 2 || TICK_DIV < 1 || SLOT_PHASES < 3 ||
        ON_PHASE < 1 || ON_PHASE > SLOT_PHASES - 2) begin : g_bad_params
        $fatal(1, "scan_display_driver: illegal parameter combination");
    end

    logic            tick;
    logic [PH_W-1:0] phase;
    logic [DG_W-1:0] digit;
    logic            frame_end;
    logic            frame_commit;
    logic [DG_W-1:0] digit_sel;

    logic [CV_W-1:0]       sh_chars_q, sh_chars_d, act_chars_q, act_chars_d;
    logic [NUM_DIGITS-1:0] sh_en_q, sh_en_d, act_en_q, act_en_d;
    logic                  pending_q, pending_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [CHAR_W-1:0]     char_q, char_d;
    logic [DG_W-1:0]       idx_q, idx_d;
    logic                  fe_dly_q, fd_q, fd_d;

    scan_timebase #(
        .NUM_DIGITS (NUM_DIGITS),
        .TICK_DIV   (TICK_DIV),
        .SLOT_PHASES(SLOT_PHASES)
    ) u_timebase (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .tick     (tick),
        .phase    (phase),
        .digit    (digit),
        .frame_end(frame_end)
    );

    assign frame_commit = tick && frame_end;
    // Counters are still non-zero during the first disabled cycle.
    assign digit_sel    = enable ? digit : '0;

    // Shadow capture and commit into the active buffer.
    always_comb begin
        sh_chars_d  = sh_chars_q;
        sh_en_d     = sh_en_q;
        act_chars_d = act_chars_q;
        act_en_d    = act_en_q;
        pending_d   = pending_q;
        if (load) begin
            sh_chars_d = chars_in;
            sh_en_d    = digit_en_in;
        end else begin
            sh_chars_d = sh_chars_q;
            sh_en_d    = sh_en_q;
        end
        if (load && frame_commit) begin
            act_chars_d = chars_in;
            act_en_d    = digit_en_in;
            pending_d   = 1'b0;
        end else if (pending_q && (frame_commit || !enable)) begin
            act_chars_d = sh_chars_q;
            act_en_d    = sh_en_q;
            pending_d   = load;
        end else begin
            pending_d   = pending_q | load;
        end
    end

    // Next values of the registered display outputs.
    always_comb begin
        an_d   = '1;
        char_d = act_chars_q[int'(digit_sel) * CHAR_W +: CHAR_W];
        idx_d  = digit_sel;
        fd_d   = fe_dly_q & enable;
        if (enable && (phase == PH_W'(ON_PHASE)) && act_en_q[digit_sel]) begin
            an_d[digit_sel] = 1'b0;
        end else begin
            an_d = '1;
        end
    end

    // Buffer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_chars_q  <= '0;
            sh_en_q     <= '0;
            act_chars_q <= '0;
            act_en_q    <= '0;
            pending_q   <= 1'b0;
            an_q        <= '1;
            char_q      <= '0;
            idx_q       <= '0;
            fe_dly_q    <= 1'b0;
            fd_q        <= 1'b0;
        end else begin
            sh_chars_q  <= sh_chars_d;
            sh_en_q     <= sh_en_d;
            act_chars_q <= act_chars_d;
            act_en_q    <= act_en_d;
            pending_q   <= pending_d;
            an_q        <= an_d;
            char_q      <= char_d;
            idx_q       <= idx_d;
            fe_dly_q    <= frame_commit;
            fd_q        <= fd_d;
        end
    end

    assign an         = an_q;
    assign char_out   = char_q;
    assign digit_idx  = idx_q;
    assign pending    = pending_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_scan_display_driver.sv
// Scoreboard bench: stimulus queues expected {anode, char} on-windows,
// a monitor pops one per on-window seen on the anodes.
module tb_scan_display_driver;

    localparam int ND    = 4;
    localparam int CW    = 4;
    localparam int TD    = 2;
    localparam int SP    = 4;
    localparam int OP    = 2;
    localparam int FRAME = ND * SP * TD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] chars_in = 16'h0000;
    logic [3:0]  digit_en_in = 4'h0;
    logic [3:0]  an;
    logic [3:0]  char_out;
    logic [1:0]  digit_idx;
    logic        pending;
    logic        frame_done;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    scan_display_driver #(
        .NUM_DIGITS(ND), .CHAR_W(CW), .TICK_DIV(TD), .SLOT_PHASES(SP), .ON_PHASE(OP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
        .chars_in(chars_in), .digit_en_in(digit_en_in),
        .an(an), .char_out(char_out), .digit_idx(digit_idx),
        .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_fd(output int n);
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < 4 * FRAME) begin
            @(posedge clk); #1;
            n++;
            got = frame_done;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL wait_fd: no frame_done within %0d cycles", n);
        end
    endtask

    task automatic wait_idx(input logic [1:0] d);
        int n;
        n = 0;
        while (digit_idx != d && n < 2 * FRAME) begin
            @(posedge clk); #1;
            n++;
        end
        if (digit_idx != d) begin
            total++; bad++;
            $display("FAIL wait_idx: digit_idx %0d never seen, last %0d", d, digit_idx);
        end
    endtask

    task automatic wait_on(output int n);
        n = 0;
        while (an == 4'hF && n < 2 * FRAME) begin
            @(posedge clk); #1;
            n++;
        end
        if (an == 4'hF) begin
            total++; bad++;
            $display("FAIL wait_on: no anode went low within %0d cycles", n);
        end
    endtask

    // Monitor: each on-window start is matched against the scoreboard.
    initial begin
        logic [3:0] an_prev;
        logic       fd_prev;
        int         win_len;
        logic [7:0] e;
        an_prev = 4'hF;
        fd_prev = 1'b0;
        win_len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                an_prev = 4'hF;
                fd_prev = 1'b0;
                win_len = 0;
            end else begin
                if (an != 4'hF && an_prev == 4'hF) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL window: got %0h expected none", {an, char_out});
                    end else begin
                        e = exp_q.pop_front();
                        check("window", int'({an, char_out}), int'(e));
                    end
                    win_len = 1;
                end else if (an != 4'hF) begin
                    win_len++;
                end else if (an_prev != 4'hF) begin
                    check("window_len", win_len, TD);
                end
                if (frame_done) check("fd_one_cycle", int'(fd_prev), 0);
                fd_prev = frame_done;
                an_prev = an;
            end
        end
    end

    initial begin
        int n;
        #3 rst_n = 1'b0;
        cyc(3);
        check("rst_an", int'(an), 'hF);
        check("rst_char", int'(char_out), 0);
        check("rst_idx", int'(digit_idx), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_fd", int'(frame_done), 0);
        rst_n = 1'b1;
        cyc(1);

        // First frame dark while 4321 waits in the shadow buffer.
        enable = 1'b1; load = 1'b1; chars_in = 16'h4321; digit_en_in = 4'b1111;
        push4(8'hE1, 8'hD2, 8'hB3, 8'h74);
        cyc(1);
        load = 1'b0;
        check("pending_set", int'(pending), 1);
        wait_fd(n);
        check("fd_latency", n, FRAME);
        check("pending_commit", int'(pending), 0);
        check("fd_idx0", int'(digit_idx), 0);
        check("fd_char0", int'(char_out), 'h1);

        // Mid-frame load must not tear the frame in progress.
        wait_idx(2'd1);
        load = 1'b1; chars_in = 16'hABCD;
        push4(8'hED, 8'hDC, 8'hBB, 8'h7A);
        cyc(1);
        load = 1'b0;
        check("pending_mid", int'(pending), 1);
        wait_fd(n);
        check("pending_mid_commit", int'(pending), 0);

        // Partial digit enable 1010.
        load = 1'b1; chars_in = 16'h5678; digit_en_in = 4'b1010;
        exp_q.push_back(8'hD7);
        exp_q.push_back(8'h75);
        cyc(1);
        load = 1'b0;
        wait_fd(n);
        wait_fd(n);

        // Drop enable before digit 1 reaches its on-phase.
        wait_idx(2'd1);
        enable = 1'b0;
        cyc(1);
        check("dis_an", int'(an), 'hF);
        check("dis_idx", int'(digit_idx), 0);
        load = 1'b1; chars_in = 16'h1234; digit_en_in = 4'b1111;
        cyc(1);
        load = 1'b0;
        check("dis_pending_set", int'(pending), 1);
        check("dis_fd0", int'(frame_done), 0);
        cyc(1);
        check("dis_pending_clr", int'(pending), 0);
        cyc(1);
        check("dis_char", int'(char_out), 'h4);
        check("dis_fd1", int'(frame_done), 0);

        // Restart: digit 0 on-window after 2*TD counter steps plus output lag.
        push4(8'hE4, 8'hD3, 8'hB2, 8'h71);
        enable = 1'b1;
        wait_on(n);
        check("restart_latency", n, 2 * TD + 1);
        check("restart_an", int'(an), 'hE);
        wait_fd(n);
        push4(8'hE4, 8'hD3, 8'hB2, 8'h71);

        // Load on the exact frame-boundary cycle (counters at last state).
        cyc(FRAME - 2);
        load = 1'b1; chars_in = 16'hFEDC;
        push4(8'hEC, 8'hDD, 8'hBE, 8'h7F);
        cyc(1);
        load = 1'b0;
        check("bnd_pending", int'(pending), 0);
        wait_fd(n);
        check("bnd_fd_next", n, 1);

        // Asynchronous reset in the middle of an on-window.
        load = 1'b1; chars_in = 16'h2222;
        cyc(1);
        load = 1'b0;
        check("pre_rst_pending", int'(pending), 1);
        wait_on(n);
        #2 rst_n = 1'b0;
        #1;
        check("arst_an", int'(an), 'hF);
        check("arst_char", int'(char_out), 0);
        check("arst_pending", int'(pending), 0);
        check("arst_idx", int'(digit_idx), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        load = 1'b1; chars_in = 16'h8765;
        cyc(1);
        load = 1'b0;
        check("post_rst_idx", int'(digit_idx), 0);
        wait_fd(n);
        check("post_rst_fd_latency", n, FRAME);
        push4(8'hE5, 8'hD6, 8'hB7, 8'h78);
        wait_fd(n);
        enable = 1'b0;
        cyc(3);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
